// File: rtl/upload_arbiter.sv
// Round-robin frame arbiter: merges NUM_CHANNELS byte streams onto one upload port,
// holding a grant for a whole frame and revoking it when the owner stalls too long.
module upload_arbiter #(
    parameter int NUM_CHANNELS   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CHANNELS-1:0]   in_req,
    input  logic [NUM_CHANNELS*8-1:0] in_data,
    input  logic [NUM_CHANNELS*8-1:0] in_source,
    input  logic [NUM_CHANNELS-1:0]   in_valid,
    output logic [NUM_CHANNELS-1:0]   in_ready,
    output logic                      out_req,
    output logic [7:0]                out_data,
    output logic [7:0]                out_source,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CHANNELS-1:0]   grant,
    output logic                      timeout_pulse
);

    localparam int              LGW     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [LGW-1:0]  LAST_CH = LGW'(NUM_CHANNELS - 1);
    localparam logic [15:0]     TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_GAP} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_CHANNELS-1:0] r_grant;
    logic [LGW-1:0]          r_gidx;
    logic [LGW-1:0]          r_last_grant;
    logic [15:0]             r_cnt;
    logic                    r_timeout_pulse;

    logic                      w_granted;
    logic                      w_any_req;
    logic                      w_req_g;
    logic                      w_xfer;
    logic                      w_timeout;
    logic [2*NUM_CHANNELS-1:0] w_rot;
    logic                      w_found;
    int                        w_sum;
    logic [LGW-1:0]            w_pick;

    assign w_granted = (r_state == S_GRANTED);
    assign w_req_g   = |(in_req & r_grant);
    assign w_xfer    = w_granted & out_valid & out_ready;
    assign w_timeout = TO_EN & w_granted & ~w_xfer & (r_cnt == TO_LAST);

    // Rotate the request vector so bit 0 is the channel after last_grant; first set bit wins.
    always_comb begin
        w_any_req = |in_req;
        w_rot     = {in_req, in_req} >> (int'(r_last_grant) + 1);
        w_found   = 1'b0;
        w_sum     = 0;
        w_pick    = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = int'(r_last_grant) + 1 + j;
                if (w_sum >= NUM_CHANNELS) begin
                    w_sum = w_sum - NUM_CHANNELS;
                end
                w_pick = w_sum[LGW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_gidx          <= '0;
            r_last_grant    <= LAST_CH;
            r_cnt           <= 16'd0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_timeout_pulse <= 1'b0;
            if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= NUM_CHANNELS'(1) << w_pick;
                        r_gidx  <= w_pick;
                        r_cnt   <= 16'd0;
                    end
                end
                S_GRANTED: begin
                    if (w_xfer) begin
                        r_cnt <= 16'd0;
                    end
                    // A normal release takes precedence, so the pulse only fires while req is still high.
                    if (!w_req_g || w_timeout) begin
                        r_last_grant    <= r_gidx;
                        r_grant         <= '0;
                        r_timeout_pulse <= w_req_g;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_state_next = S_GRANTED;
            S_GRANTED: if (!w_req_g || w_timeout) w_state_next = S_GAP;
            S_GAP:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_req    = w_granted;
        out_data   = 8'h00;
        out_source = 8'h00;
        out_valid  = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (w_granted && r_grant[k]) begin
                out_data   = in_data[k*8 +: 8];
                out_source = in_source[k*8 +: 8];
                out_valid  = in_valid[k];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ready
        assign in_ready[gi] = w_granted & r_grant[gi] & out_ready;
    end

    assign grant         = r_grant;
    assign timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_upload_arbiter.sv
// Directed bench for upload_arbiter: two channels, 8-cycle timeout, hand-computed expectations.
module tb_upload_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_req;
    logic [15:0] in_data;
    logic [15:0] in_source;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic        out_req;
    logic [7:0]  out_data;
    logic [7:0]  out_source;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  grant;
    logic        timeout_pulse;

    int errors = 0;
    int checks = 0;

    logic [7:0] sf_bytes [7] = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h01, 8'h5A, 8'hF0};
    logic [7:0] bp_bytes [4] = '{8'h31, 8'h32, 8'h33, 8'h34};

    upload_arbiter #(.NUM_CHANNELS(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_req(in_req), .in_data(in_data), .in_source(in_source),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_req(out_req), .out_data(out_data), .out_source(out_source),
        .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_req = 2'b00; in_valid = 2'b00; in_data = 16'h0000;
        in_source = 16'h0201; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b exp=00", grant); end
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL rst_out_req got=%b exp=0", out_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        checks++; if (out_source !== 8'h00) begin errors++; $display("FAIL rst_out_source got=%h exp=00", out_source); end
        checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL rst_in_ready got=%b exp=00", in_ready); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL rst_timeout_pulse got=%b exp=0", timeout_pulse); end
        step();
        rst_n = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_single_frame();
        in_req = 2'b01; in_valid = 2'b01; in_data[7:0] = sf_bytes[0]; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL sf_idle got req=%b grant=%b exp req=0 grant=00", out_req, grant); end
        step();
        for (int i = 0; i < 7; i++) begin
            in_data[7:0] = sf_bytes[i];
            @(negedge clk);
            checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sf_grant[%0d] got=%b exp=01", i, grant); end
            checks++; if (out_valid !== 1'b1 || out_data !== sf_bytes[i]) begin errors++; $display("FAIL sf_byte[%0d] got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, sf_bytes[i]); end
            checks++; if (out_source !== 8'h01 || in_ready !== 2'b01) begin errors++; $display("FAIL sf_src_rdy[%0d] got src=%h rdy=%b exp src=01 rdy=01", i, out_source, in_ready); end
            $display("single_frame: byte %0d data=%h", i, out_data);
            step();
        end
        in_req = 2'b00; in_valid = 2'b00;
        @(negedge clk);
        checks++; if (out_req !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL sf_release got req=%b valid=%b exp req=1 valid=0", out_req, out_valid); end
        step();
        @(negedge clk);
        checks++; if (out_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL sf_gap got req=%b grant=%b exp req=0 grant=00", out_req, grant); end
        step();
        @(negedge clk);
        checks++; if (out_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL sf_idle2 got req=%b grant=%b exp req=0 grant=00", out_req, grant); end
        step();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        int ch;
        rst_n = 1'b0; in_req = 2'b00; in_valid = 2'b00; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            ch    = f % 2;
            exp_g = (f == 1) ? 2'b10 : 2'b01;
            in_req = 2'b11; in_valid = 2'b11;
            @(negedge clk);
            checks++; if (out_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL ct_idle[%0d] got req=%b grant=%b exp req=0 grant=00", f, out_req, grant); end
            step();
            for (int b = 0; b < 3; b++) begin
                in_data = {8'(8'h80 + f*8 + b), 8'(8'h40 + f*8 + b)};
                exp_d   = (ch == 1) ? 8'(8'h80 + f*8 + b) : 8'(8'h40 + f*8 + b);
                @(negedge clk);
                checks++; if (grant !== exp_g || in_ready !== exp_g) begin errors++; $display("FAIL ct_grant[%0d.%0d] got grant=%b rdy=%b exp=%b", f, b, grant, in_ready, exp_g); end
                checks++; if (out_data !== exp_d) begin errors++; $display("FAIL ct_data[%0d.%0d] got=%h exp=%h", f, b, out_data, exp_d); end
                step();
            end
            in_req[ch] = 1'b0; in_valid[ch] = 1'b0;
            @(negedge clk);
            checks++; if (out_req !== 1'b1 || grant !== exp_g) begin errors++; $display("FAIL ct_release[%0d] got req=%b grant=%b exp req=1 grant=%b", f, out_req, grant, exp_g); end
            step();
            in_req = 2'b11;
            @(negedge clk);
            checks++; if (out_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL ct_gap[%0d] got req=%b grant=%b exp req=0 grant=00", f, out_req, grant); end
            $display("contention: frame %0d from ch%0d", f, ch);
            step();
        end
        in_req = 2'b00; in_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] rx [8];
        int nrx = 0;
        int idx = 0;
        int cyc = 0;
        logic orr;
        in_req = 2'b10; in_valid = 2'b10; in_data[15:8] = bp_bytes[0]; out_ready = 1'b1;
        @(negedge clk);
        step();
        while (idx < 4 && cyc < 20) begin
            orr = (cyc % 2 == 0);
            out_ready = orr;
            in_data[15:8] = bp_bytes[idx];
            @(negedge clk);
            checks++; if (in_ready !== {orr, 1'b0}) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=%b", cyc, in_ready, {orr, 1'b0}); end
            if (out_valid === 1'b1 && out_ready && nrx < 8) begin
                rx[nrx] = out_data;
                nrx++;
            end
            $display("backpressure: cycle %0d out_ready=%b data=%h", cyc, orr, out_data);
            if (orr) idx++;
            step();
            cyc++;
        end
        checks++; if (nrx !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", nrx); end
        for (int i = 0; i < 4 && i < nrx; i++) begin
            checks++; if (rx[i] !== bp_bytes[i]) begin errors++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, rx[i], bp_bytes[i]); end
        end
        in_req = 2'b00; in_valid = 2'b00; out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_timeout();
        in_req = 2'b10; in_valid = 2'b10; in_data[15:8] = 8'h55; out_ready = 1'b1;
        @(negedge clk);
        step();
        in_req = 2'b11;
        @(negedge clk);
        checks++; if (grant !== 2'b10 || out_valid !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL to_first got grant=%b valid=%b data=%h exp 10/1/55", grant, out_valid, out_data); end
        step();
        in_valid = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++; if (grant !== 2'b10 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_hold[%0d] got grant=%b pulse=%b exp 10/0", i, grant, timeout_pulse); end
            step();
        end
        @(negedge clk);
        checks++; if (timeout_pulse !== 1'b1 || grant !== 2'b00 || out_req !== 1'b0) begin errors++; $display("FAIL to_gap got pulse=%b grant=%b req=%b exp 1/00/0", timeout_pulse, grant, out_req); end
        $display("timeout: pulse=%b", timeout_pulse);
        step();
        @(negedge clk);
        checks++; if (timeout_pulse !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL to_idle got pulse=%b grant=%b exp 0/00", timeout_pulse, grant); end
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_next got grant=%b exp=01", grant); end
        in_req = 2'b00;
        step();
        step();
    endtask

    task automatic test_release_at_timeout();
        in_req = 2'b10; in_valid = 2'b00;
        @(negedge clk);
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) in_req = 2'b00;
            @(negedge clk);
            checks++; if (grant !== 2'b10 || out_req !== 1'b1) begin errors++; $display("FAIL rt_hold[%0d] got grant=%b req=%b exp 10/1", i, grant, out_req); end
            step();
        end
        @(negedge clk);
        checks++; if (timeout_pulse !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rt_gap got pulse=%b grant=%b exp 0/00", timeout_pulse, grant); end
        $display("release_at_timeout: pulse=%b", timeout_pulse);
        step();
        step();
    endtask

    task automatic test_reset_midframe();
        in_req = 2'b10; in_valid = 2'b10; in_data[15:8] = 8'h61; out_ready = 1'b1;
        @(negedge clk);
        step();
        for (int b = 0; b < 2; b++) begin
            in_data[15:8] = 8'(8'h61 + b);
            @(negedge clk);
            checks++; if (grant !== 2'b10 || out_data !== 8'(8'h61 + b)) begin errors++; $display("FAIL rm_byte[%0d] got grant=%b data=%h exp 10/%h", b, grant, out_data, 8'(8'h61 + b)); end
            step();
        end
        in_data[15:8] = 8'h63;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_req !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rm_async got valid=%b req=%b data=%h exp 0/0/00", out_valid, out_req, out_data); end
        checks++; if (grant !== 2'b00 || in_ready !== 2'b00 || out_source !== 8'h00) begin errors++; $display("FAIL rm_async2 got grant=%b rdy=%b src=%h exp 00/00/00", grant, in_ready, out_source); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_held got valid=%b exp 0", out_valid); end
        step();
        rst_n = 1'b1; in_req = 2'b11; in_valid = 2'b11; in_data = 16'h7271;
        @(negedge clk);
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL rm_idle got req=%b exp 0", out_req); end
        step();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || out_data !== 8'h71) begin errors++; $display("FAIL rm_first got grant=%b data=%h exp 01/71", grant, out_data); end
        $display("reset_midframe: grant after reset=%b", grant);
        in_req = 2'b00; in_valid = 2'b00;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_backpressure();
        test_timeout();
        test_release_at_timeout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
